// File: rtl/issue_buffer_if.sv
// Dispatcher/functional-unit handshake bundle for the issue buffer.
// The master side drives requests; the slave side (the buffer) drives status and the issue field.
interface issue_buffer_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FIELD_WIDTH = 55,
    parameter int unsigned DEPTH       = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                   enq_i;
    logic [XLEN-1:0]        data_i;
    logic                   flush_i;
    logic                   fu_ready_i;
    logic                   issue_valid_o;
    logic [FIELD_WIDTH-1:0] issue_data_o;
    logic                   full_o;
    logic                   empty_o;
    logic [CNT_W-1:0]       count_o;
    logic                   overflow_o;

    modport master (
        output enq_i, data_i, flush_i, fu_ready_i,
        input  issue_valid_o, issue_data_o, full_o, empty_o, count_o, overflow_o
    );

    modport slave (
        input  enq_i, data_i, flush_i, fu_ready_i,
        output issue_valid_o, issue_data_o, full_o, empty_o, count_o, overflow_o
    );
endinterface

// File: rtl/issue_buffer.sv
// Circular issue buffer: decodes register fields and a sequence tag at enqueue,
// presents the oldest entry first-word-fall-through to the functional unit.
module issue_buffer #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FIELD_WIDTH = 55,
    parameter int unsigned DEPTH       = 4
) (
    input  logic           clk,
    input  logic           resetn,
    issue_buffer_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SEQ_W = 8;

    typedef struct packed {
        logic [4:0]       rs2;
        logic [4:0]       rs1;
        logic [4:0]       rd;
        logic [SEQ_W-1:0] seq;
        logic [31:0]      instr;
    } field_t;

    logic [FIELD_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       count;
    logic [SEQ_W-1:0]       seq;
    logic                   overflow;

    logic   full;
    logic   empty;
    logic   do_enq;
    logic   do_iss;
    field_t new_field;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    // Flush wins over any same-edge enqueue or issue.
    assign do_enq = bus.enq_i && !full && !bus.flush_i;
    assign do_iss = !empty && bus.fu_ready_i && !bus.flush_i;

    always_comb begin
        new_field       = '0;
        new_field.rs2   = bus.data_i[24:20];
        new_field.rs1   = bus.data_i[19:15];
        new_field.rd    = bus.data_i[11:7];
        new_field.seq   = seq;
        new_field.instr = bus.data_i[31:0];
    end

    // Entry storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[tail] <= FIELD_WIDTH'(new_field);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            seq      <= '0;
            overflow <= 1'b0;
        end else begin
            if (bus.enq_i && full && !bus.flush_i) begin
                overflow <= 1'b1;
            end
            if (bus.flush_i) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_enq) begin
                    tail <= tail + PTR_W'(1);
                    seq  <= seq + SEQ_W'(1);
                end
                if (do_iss) begin
                    head <= head + PTR_W'(1);
                end
                case ({do_enq, do_iss})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign bus.issue_valid_o = !empty;
    assign bus.issue_data_o  = empty ? '0 : mem[head];
    assign bus.full_o        = full;
    assign bus.empty_o       = empty;
    assign bus.count_o       = count;
    assign bus.overflow_o    = overflow;
endmodule

// File: doc/issue_buffer.md
ISSUE_BUFFER -- requirements
Module: issue_buffer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, instruction word width.
REQ-002 The block SHALL have parameter FIELD_WIDTH, default 55, issued field width; fixed at 55 for the field layout in REQ-016.
REQ-003 The block SHALL have parameter DEPTH, default 4, entry count; power of two, 2..16.
REQ-004 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port enq_i  input  1  enqueue request from dispatcher, one instruction per cycle.
REQ-007 The block SHALL have port data_i  input  XLEN  raw instruction word accompanying enq_i.
REQ-008 The block SHALL have port flush_i  input  1  synchronous discard of all held entries.
REQ-009 The block SHALL have port fu_ready_i  input  1  functional unit can accept an issue this cycle.
REQ-010 The block SHALL have port issue_valid_o  output  1  issue_data_o holds a valid entry.
REQ-011 The block SHALL have port issue_data_o  output  FIELD_WIDTH  decoded field of the oldest entry.
REQ-012 The block SHALL have ports full_o and empty_o  output  1 each  occupancy status.
REQ-013 The block SHALL have port count_o  output  clog2(DEPTH)+1  current occupancy.
REQ-014 The block SHALL have port overflow_o  output  1  sticky flag: enqueue attempted while full.

Function
REQ-015 The block SHALL store entries in a circular buffer with head/tail pointers wrapping modulo DEPTH, oldest-first issue order.
REQ-016 At enqueue the block SHALL store field = {rs2=instr[24:20], rs1=instr[19:15], rd=instr[11:7], seq[7:0], instr[31:0]} (bits 54:50, 49:45, 44:40, 39:32, 31:0).
REQ-017 seq SHALL be an 8-bit counter, 0 after reset, incremented per accepted enqueue, wrapping 255->0; rejected enqueues do not increment it.
REQ-018 Latency: an entry accepted at edge N SHALL appear on issue_data_o with issue_valid_o=1 after edge N when the buffer was empty (first-word fall-through); issue_data_o is driven combinationally from the head entry register.
REQ-019 issue_valid_o SHALL equal !empty_o; issue_data_o SHALL be 0 when empty.
REQ-020 An issue transfer SHALL occur on an edge where issue_valid_o=1 and fu_ready_i=1; head advances, count decrements.
REQ-021 An enqueue SHALL be accepted on an edge where enq_i=1 and full_o=0 (state before the edge); tail advances, count increments.
REQ-022 Simultaneous accepted enqueue and issue SHALL leave count unchanged, both pointers advancing.
REQ-023 enq_i while full_o=1 SHALL be dropped even if an issue occurs on the same edge, and SHALL set overflow_o, which holds until reset.
REQ-024 enq_i while empty SHALL NOT issue on the same edge (no bypass); earliest issue is the following edge.
REQ-025 flush_i=1 SHALL on that edge clear count, head, tail to 0 and discard any same-edge enqueue or issue; seq and overflow_o are unaffected.
REQ-026 full_o SHALL be 1 iff count_o==DEPTH; empty_o SHALL be 1 iff count_o==0.

Reset
REQ-027 While resetn=0, asynchronously: count_o=0, head=tail=0, seq=0, overflow_o=0, empty_o=1, full_o=0, issue_valid_o=0, issue_data_o=0; entry storage need not be cleared.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately; first enqueue after release gets seq=0.

Verification
REQ-029 Enqueue 0x00A30233 to empty buffer, fu_ready_i=0 -> next cycle issue_valid_o=1, issue_data_o={5'd10,5'd6,5'd4,8'd0,32'h00A30233}, count_o=1.
REQ-030 Enqueue 5 words back-to-back, fu_ready_i=0, DEPTH=4 -> full_o=1 after 4th, 5th dropped, overflow_o=1, count_o=4; then fu_ready_i=1 for 4 cycles -> seq 0,1,2,3 issued in order, empty_o=1.
REQ-031 Full buffer, enq_i=1 and fu_ready_i=1 same edge -> count_o=3, enqueue dropped, overflow_o=1.
REQ-032 Two entries held, enq_i and fu_ready_i continuous for 10 cycles -> count_o stays 2, pointers wrap, issued seq strictly increasing by 1.
REQ-033 Enqueue 300 instructions with fu_ready_i=1 -> seq wraps 255->0 at the 257th; flush_i with 3 held -> empty_o=1 next cycle, no issue on flush edge.
REQ-034 Assert resetn=0 asynchronously between edges with 3 entries -> outputs reach reset values before next edge; next accepted entry carries seq=0.
